cla_adder_pipe: RTL and testbench
=================================

CLA_ADDER_PIPE -- requirements
Module: cla_adder_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, as the operand width in bits; legal values are multiples of GROUP from 4 to 64.
REQ-002 The block SHALL have parameter GROUP, default 4, as the lookahead group size in bits; only 4 is supported.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands are presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port cin, input, 1 bit: the carry-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: a+b+cin modulo 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1 bit: the carry out of bit WIDTH-1.

Function
REQ-013 The block SHALL be a 2-stage pipeline. Stage S1 registers per-bit p=a^b and g=a&b, group P/G for each GROUP-bit slice, and cin. Stage S2 registers sum and cout.
REQ-014 S2 SHALL compute group carries as c[k+1]=G[k] | (P[k] & c[k]), with c[0]=registered cin.
REQ-015 S2 SHALL compute in-group carries by 4-bit lookahead from the group carry, and sum[i]=p[i]^c[i].
REQ-016 A transfer SHALL occur on in_valid&&in_ready on the input side, and on out_valid&&out_ready on the output side.
REQ-017 Latency SHALL be 2 cycles from input transfer to out_valid with out_ready held high, at a throughput of 1 result per cycle.
REQ-018 Each stage SHALL advance when its successor is empty or is transferring in the same cycle. Consequently in_ready = !s1_valid || s2_advance, and s2_advance = !out_valid || out_ready.
REQ-019 With out_ready low and out_valid high, sum, cout and out_valid SHALL hold stable. S1 SHALL fill, then in_ready SHALL drop in the same cycle S1 becomes full.
REQ-020 in_ready SHALL NOT depend combinationally on in_valid.
REQ-021 Simultaneous input and output transfers SHALL sustain full throughput with no bubble.
REQ-022 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-023 Wrap-around: the carry SHALL propagate through all groups within S2. For example, all-ones + 0 with cin=1 gives sum=0 and cout=1.
REQ-024 Operand values SHALL NOT affect handshake timing.

Reset
REQ-025 On rst asserted, s1_valid, out_valid, sum, cout and all S1 registers SHALL clear to 0 asynchronously.
REQ-026 in_ready SHALL read 1 while in reset and after reset.
REQ-027 Reset mid-operation SHALL discard all in-flight results. After rst deasserts, the first out_valid SHALL correspond to the first post-reset input transfer.

Configuration
REQ-028 With macro CLA_OVERFLOW_EN defined, the block SHALL add output port ovf, 1 bit: the signed overflow flag, equal to c[WIDTH]^c[WIDTH-1]. ovf SHALL be registered in S2 alongside sum, reset to 0, and held under stall like sum.
REQ-029 With CLA_OVERFLOW_EN undefined, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package cla_pkg SHALL hold:
- constant CLA_GROUP = 4
- function cla_ngroups(width) returning width/CLA_GROUP
- typedef gp_t (struct with p and g bits)
REQ-031 Sub-module gp_logic_n SHALL be the single natural sub-module: a combinational per-bit p/g generator parametrised by WIDTH, instantiated once in S1.
REQ-032 An elaboration-time check SHALL fail if WIDTH mod GROUP != 0 or GROUP != 4.

Verification
REQ-033 Reset-release scenario: rst pulse, then idle. Required: out_valid=0, sum=0, cout=0, in_ready=1.
REQ-034 Ripple-through scenario: WIDTH=16, a=0xFFFF, b=0x0000, cin=1, out_ready=1. Required: 2 cycles later out_valid=1, sum=0x0000, cout=1.
REQ-035 Back-to-back stream scenario: a=0x1234/b=0x4321, then a=0x8000/b=0x8000, then a=0x00FF/b=0x0001, all cin=0, out_ready=1. Required in order:
- sum=0x5555, cout=0
- sum=0x0000, cout=1
- sum=0x0100, cout=0
No idle cycles between them.
REQ-036 Backpressure scenario: out_ready=0 while 3 inputs are offered. Required: 2 accepted, then in_ready=0, and the output holds the first result unchanged. Raising out_ready SHALL drain all 3 results in order.
REQ-037 Reset-during-flight scenario: assert rst with 2 results in flight. Required: no out_valid for either; the next accepted input appears 2 cycles after acceptance.
REQ-038 Overflow scenario, with CLA_OVERFLOW_EN defined: a=0x7FFF, b=0x0001. Required: sum=0x8000, ovf=1. For a=0xFFFF, b=0x0001, required: ovf=0, cout=1.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_GROUP = 4;

  typedef struct packed {
    logic p;
    logic g;
  } gp_t;

  function automatic int cla_ngroups(input int width);
    return width / CLA_GROUP;
  endfunction

endpackage

// File: rtl/gp_logic_n.sv
// Per-bit propagate/generate for a WIDTH-bit operand pair.
// Latency: combinational.
// Backpressure: none; pure logic.
module gp_logic_n
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output gp_t  [WIDTH-1:0] gp
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign gp[i].p = a[i] ^ b[i];
    assign gp[i].g = a[i] & b[i];
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage carry-lookahead adder; CLA_OVERFLOW_EN adds a registered signed-overflow flag (ovf).
// Latency: 2 cycles from input transfer to out_valid, 1 result per cycle.
// Backpressure: valid/ready; output holds under stall, S1 fills then in_ready drops.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = cla_ngroups(WIDTH);

  if ((WIDTH % GROUP) != 0 || GROUP != CLA_GROUP || WIDTH < 4 || WIDTH > 64) begin : g_bad_cfg
    $error("cla_adder_pipe: WIDTH must be a multiple of 4 in 4..64 and GROUP must be 4");
  end

  // ---------------- S1: bit and group propagate/generate ----------------
  gp_t [WIDTH-1:0] bit_gp;
  gp_t [NG-1:0]    grp_gp;

  gp_logic_n #(.WIDTH(WIDTH)) u_gp (
    .a  (a),
    .b  (b),
    .gp (bit_gp)
  );

  for (genvar k = 0; k < NG; k++) begin : g_grp
    assign grp_gp[k].p = bit_gp[4*k+3].p & bit_gp[4*k+2].p & bit_gp[4*k+1].p & bit_gp[4*k].p;
    assign grp_gp[k].g = bit_gp[4*k+3].g
                       | (bit_gp[4*k+3].p & bit_gp[4*k+2].g)
                       | (bit_gp[4*k+3].p & bit_gp[4*k+2].p & bit_gp[4*k+1].g)
                       | (bit_gp[4*k+3].p & bit_gp[4*k+2].p & bit_gp[4*k+1].p & bit_gp[4*k].g);
  end

  logic            s1_valid;
  gp_t [WIDTH-1:0] s1_bit;
  gp_t [NG-1:0]    s1_grp;
  logic            s1_cin;
  logic            s2_advance;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bit   <= '0;
      s1_grp   <= '0;
      s1_cin   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_bit <= bit_gp;
        s1_grp <= grp_gp;
        s1_cin <= cin;
      end
    end
  end

  // ---------------- S2: group ripple, in-group lookahead, sum ----------------
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;

  // Only the group carry ripples; the three inner carries come straight from it.
  always_comb begin : carry_c
    logic cg;
    cg = s1_cin;
    c  = '0;
    for (int k = 0; k < NG; k++) begin
      c[4*k]   = cg;
      c[4*k+1] = s1_bit[4*k].g | (s1_bit[4*k].p & cg);
      c[4*k+2] = s1_bit[4*k+1].g
               | (s1_bit[4*k+1].p & s1_bit[4*k].g)
               | (s1_bit[4*k+1].p & s1_bit[4*k].p & cg);
      c[4*k+3] = s1_bit[4*k+2].g
               | (s1_bit[4*k+2].p & s1_bit[4*k+1].g)
               | (s1_bit[4*k+2].p & s1_bit[4*k+1].p & s1_bit[4*k].g)
               | (s1_bit[4*k+2].p & s1_bit[4*k+1].p & s1_bit[4*k].p & cg);
      cg = s1_grp[k].g | (s1_grp[k].p & cg);
    end
    c[WIDTH] = cg;
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < WIDTH; i++) sum_d[i] = s1_bit[i].p ^ c[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef CLA_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_d;
        cout <= c[WIDTH];
`ifdef CLA_OVERFLOW_EN
        ovf  <= c[WIDTH] ^ c[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: table vectors, stall/reset sequences, random stream vs arithmetic model.
module tb_cla_adder_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
`ifdef CLA_OVERFLOW_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CLA_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;
  bit   chk_lat = 1'b0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] t;
    exp_t r;
    t    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    r.s  = t[W-1:0];
    r.co = t[W];
    r.ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    r.cyc = 0;
    return r;
  endfunction

  // Output scoreboard: every output transfer must match the oldest accepted input.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(mon_e.s));
        check("cout", 32'(cout), 32'(mon_e.co));
`ifdef CLA_OVERFLOW_EN
        check("ovf", 32'(ovf), 32'(mon_e.ov));
`endif
        if (chk_lat) check("latency", 32'(cyc - mon_e.cyc), 32'(2));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input exp_t e);
    int   n;
    exp_t ee;
    ee = e;
    n  = 0;
    a = x; b = y; cin = ci; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("accept", 32'(in_ready), 32'(1));
    if (in_ready) begin
      ee.cyc = cyc;
      exp_q.push_back(ee);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    exp_t e;
    logic [W-1:0] ra, rb;
    logic         rc;

    tbl[0] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[3] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[7] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};

    // Reset state, during and after reset
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("idle_out_valid", 32'(out_valid), 32'(0));
      check("idle_in_ready", 32'(in_ready), 32'(1));
    end

    // Table vectors, back to back with out_ready high: exact 2-cycle latency, no bubbles
    @(posedge clk); #1;
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = '{tbl[i].s, tbl[i].co, tbl[i].ov, 0};
      send(tbl[i].a, tbl[i].b, tbl[i].ci, e);
    end
    drain("table_drain");

    // Backpressure: 2 accepted, then in_ready low and output frozen on the first result
    @(posedge clk); #1;
    chk_lat = 1'b0;
    out_ready = 1'b0;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("bp_accept0", 32'(in_ready), 32'(1));
    e = model(a, b, cin); e.cyc = cyc; exp_q.push_back(e);
    @(posedge clk); #1;
    a = 16'h8000; b = 16'h8000;
    @(negedge clk);
    check("bp_accept1", 32'(in_ready), 32'(1));
    e = model(a, b, cin); e.cyc = cyc; exp_q.push_back(e);
    @(posedge clk); #1;
    a = 16'h00FF; b = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'(0));
      check("bp_hold_valid", 32'(out_valid), 32'(1));
      check("bp_hold_sum", 32'(sum), 32'(16'h5555));
      check("bp_hold_cout", 32'(cout), 32'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_ready", 32'(in_ready), 32'(1));
    e = model(a, b, cin); e.cyc = cyc; exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("bp_drain");

    // Reset with two results in flight: neither may appear
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'h0F0F, 16'h0101, 1'b0, model(16'h0F0F, 16'h0101, 1'b0));
    send(16'h3333, 16'h4444, 1'b1, model(16'h3333, 16'h4444, 1'b1));
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rstfl_out_valid", 32'(out_valid), 32'(0));
    check("rstfl_sum", 32'(sum), 32'(0));
    check("rstfl_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstfl_no_stale", 32'(out_valid), 32'(0));
    end
    @(posedge clk); #1;
    chk_lat = 1'b1;
    send(16'h2468, 16'h1357, 1'b1, model(16'h2468, 16'h1357, 1'b1));
    drain("rstfl_drain");

    // Random stream with random gaps and random out_ready
    @(posedge clk); #1;
    chk_lat = 1'b0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          ra = W'($urandom);
          rb = W'($urandom);
          rc = 1'($urandom_range(0, 1));
          send(ra, rb, rc, model(ra, rb, rc));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("rand_drain");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
